reg_file_32x32: RTL

REG_FILE_32X32 -- requirements
Module: reg_file_32x32

---
 rtl/reg_file_32x32_pkg.sv | 20 ++
 rtl/reg_file_32x32_decoder.sv | 18 +
 rtl/reg_file_32x32.sv | 79 +++++++
 3 files changed

// File: rtl/reg_file_32x32_pkg.sv
// rtl/reg_file_32x32_pkg.sv - shared widths and constants for the 32x32 register file
package reg_file_32x32_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT  = 32;
    localparam int WR_COUNT_W = 16;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    // Datapath write-address select: rd for R-type results, rt otherwise.
    function automatic logic [REG_ADDR_W-1:0] sel_wr_addr(
        input logic                  reg_dst,
        input logic [REG_ADDR_W-1:0] rt,
        input logic [REG_ADDR_W-1:0] rd
    );
        return reg_dst ? rd : rt;
    endfunction

endpackage

// File: rtl/reg_file_32x32_decoder.sv
// rtl/reg_file_32x32_decoder.sv - 5-to-32 one-hot write-enable decoder
module decoder_5to32
    import reg_file_32x32_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic                  en,
    output logic [REG_COUNT-1:0]  onehot
);

    // Exactly one bit high when enabled, all low otherwise.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot = REG_COUNT'(1) << addr;
        end
    end

endmodule

// File: rtl/reg_file_32x32.sv
// rtl/reg_file_32x32.sv - 31 writable registers, r0 hardwired to zero, two bypassed read ports
module reg_file_32x32
    import reg_file_32x32_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [REG_DATA_W-1:0] wr_data,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic [REG_DATA_W-1:0] rd_data_a,
    output logic [REG_DATA_W-1:0] rd_data_b,
    output logic                  wr_ack,
    output logic [WR_COUNT_W-1:0] wr_count
);

    logic [REG_DATA_W-1:0] regs [1:REG_COUNT-1];
    logic [REG_DATA_W-1:0] view [0:REG_COUNT-1];
    logic [REG_COUNT-1:0]  dec_onehot;
    logic [REG_COUNT-1:0]  wr_sel;
    logic                  commit;
    logic                  bypass_a;
    logic                  bypass_b;

    // Gating the decoder with rst_n makes reset win over a same-cycle write.
    decoder_5to32 u_dec (
        .addr   (wr_addr),
        .en     (wr_en & rst_n),
        .onehot (dec_onehot)
    );

    // r0 has no storage, so its enable is forced low; a write to r0 then never commits.
    assign wr_sel = dec_onehot & ~(REG_COUNT'(1) << ZERO_REG);
    assign commit = |wr_sel;

    // Bypass only for writes that will actually land, which also excludes r0 and reset.
    assign bypass_a = commit && (rd_addr_a == wr_addr);
    assign bypass_b = commit && (rd_addr_b == wr_addr);

    // Storage: clear on reset, otherwise load the selected register.
    always_ff @(posedge clk) begin
        for (int i = 1; i < REG_COUNT; i++) begin
            if (!rst_n) begin
                regs[i] <= '0;
            end else if (wr_sel[i]) begin
                regs[i] <= wr_data;
            end
        end
    end

    // Flat read view with the constant-zero r0 in slot 0.
    always_comb begin
        view[0] = '0;
        for (int i = 1; i < REG_COUNT; i++) begin
            view[i] = regs[i];
        end
    end

    // Combinational read ports with write-through bypass.
    always_comb begin
        rd_data_a = bypass_a ? wr_data : view[rd_addr_a];
        rd_data_b = bypass_b ? wr_data : view[rd_addr_b];
    end

    // Write acknowledge pulse and free-running commit counter (wraps naturally).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ack   <= 1'b0;
            wr_count <= '0;
        end else begin
            wr_ack <= commit;
            if (commit) begin
                wr_count <= wr_count + WR_COUNT_W'(1);
            end
        end
    end

endmodule
